sll_seq_shifter: RTL and testbench

- Iterative left shifter, the complement of the combinational arithmetic right-shift unit in the TP1 ALU datapath.
- Computes Z = A << B (logical, zero fill) one bit position per clock. It also reports the last bit shifted out.
- Sits beside the ALU as a multi-cycle functional unit, driven by the ALU control through a start/busy/done handshake.

---
 rtl/sll_seq_shifter_pkg.sv | 18 +
 rtl/sll_seq_shifter_if.sv | 23 ++
 rtl/sll_seq_shifter.sv | 91 +++++++++
 tb/tb_sll_seq_shifter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sll_seq_shifter_pkg.sv
// Shared definitions for the sequential ALU side units (shifters, multiplier).
package sll_seq_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } shift_state_t;

    localparam int unsigned DEFAULT_W = 8;
    localparam int unsigned CNTW      = $clog2(DEFAULT_W + 2);

    // Counter width for a given data width; the count is clamped to w+1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/sll_seq_shifter_if.sv
// Start/busy/done handshake and operand/result bus of the sequential left shifter.
interface sll_seq_shifter_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = 8
);
    logic          START;
    logic [W-1:0]  A;
    logic [SW-1:0] B;
    logic          BUSY;
    logic          DONE;
    logic [W-1:0]  Z;
    logic          CARRY;

    modport master (
        output START, A, B,
        input  BUSY, DONE, Z, CARRY
    );

    modport slave (
        input  START, A, B,
        output BUSY, DONE, Z, CARRY
    );
endinterface

// File: rtl/sll_seq_shifter.sv
// Iterative logical left shifter: Z = A << B, one bit per clock, with last bit out as CARRY.
module sll_seq_shifter
    import sll_seq_shifter_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    sll_seq_shifter_if.slave   bus
);

    localparam int unsigned    CW      = cnt_width(W);
    localparam logic [CW-1:0]  CNT_MAX = CW'(W + 1);

    shift_state_t  state, state_n;
    logic [W-1:0]  acc, acc_n;
    logic [W-1:0]  z_q, z_n;
    logic          cy, cy_n;
    logic          carry_q, carry_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] load_cnt;

    // Any amount beyond W+1 gives the same result and timing as W+1.
    always_comb begin
        if (32'(bus.B) > (W + 1)) begin
            load_cnt = CNT_MAX;
        end else begin
            load_cnt = CW'(bus.B);
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cy_n    = cy;
        cnt_n   = cnt;
        z_n     = z_q;
        carry_n = carry_q;
        case (state)
            IDLE, FIN: begin
                if (bus.START) begin
                    acc_n   = bus.A;
                    cy_n    = 1'b0;
                    cnt_n   = load_cnt;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    acc_n = {acc[W-2:0], 1'b0};
                    cy_n  = acc[W-1];
                    cnt_n = cnt - CW'(1);
                end else begin
                    z_n     = acc;
                    carry_n = cy;
                    state_n = FIN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            acc     <= '0;
            cy      <= 1'b0;
            cnt     <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cy      <= cy_n;
            cnt     <= cnt_n;
            z_q     <= z_n;
            carry_q <= carry_n;
        end
    end

    assign bus.BUSY  = (state == SHIFT);
    assign bus.DONE  = (state == FIN);
    assign bus.Z     = z_q;
    assign bus.CARRY = carry_q;

endmodule

// File: tb/tb_sll_seq_shifter.sv
// Bench for sll_seq_shifter: directed boundary cases plus random traffic against a timestamp model.
module tb_sll_seq_shifter;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 8;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    sll_seq_shifter_if #(.W(W), .SW(SW)) bus ();

    sll_seq_shifter #(.W(W), .SW(SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: shift in a 16-bit field; bit 8 is the last bit pushed out of bit 7.
    function automatic logic [7:0] ref_z(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] wide;
        wide = {8'h00, a} << b;
        return wide[7:0];
    endfunction

    function automatic logic ref_c(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] wide;
        wide = {8'h00, a} << b;
        return wide[8];
    endfunction

    // Model: an accepted op completes on edge accept + min(B,9) + 1; outputs latch then.
    int         edge_n    = 0;
    bit         m_act     = 1'b0;
    int         m_done_at = 0;
    bit         m_done    = 1'b0;
    logic [7:0] m_z       = 8'h00;
    logic       m_c       = 1'b0;
    logic [7:0] m_z_pend  = 8'h00;
    logic       m_c_pend  = 1'b0;

    always @(posedge clk) begin : model
        edge_n <= edge_n + 1;
        if (!reset_n) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_z    <= 8'h00;
            m_c    <= 1'b0;
        end else begin
            m_done <= (m_act && edge_n == m_done_at);
            if (m_act && edge_n == m_done_at) begin
                m_z   <= m_z_pend;
                m_c   <= m_c_pend;
                m_act <= 1'b0;
            end
            if (!m_act && bus.START) begin
                m_z_pend  <= ref_z(bus.A, bus.B);
                m_c_pend  <= ref_c(bus.A, bus.B);
                m_act     <= 1'b1;
                m_done_at <= edge_n + ((bus.B > 8'd9) ? 9 : int'(bus.B)) + 1;
            end
        end
    end

    bit cmp_en     = 1'b0;
    int done_seen  = 0;

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            check("busy",  bus.BUSY,  m_act);
            check("done",  bus.DONE,  m_done);
            check("z",     bus.Z,     m_z);
            check("carry", bus.CARRY, m_c);
            if (bus.DONE) done_seen++;
        end
    end

    // Called just after a negedge; returns edges from acceptance (edge 1) to DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int edges, output int busy_cycles);
        bus.A     = a;
        bus.B     = b;
        bus.START = 1'b1;
        edges       = 0;
        busy_cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.START = 1'b0;
            if (bus.BUSY) busy_cycles++;
            if (bus.DONE) begin
                edges = i;
                break;
            end
        end
        if (edges == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.DONE) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(name, 32'd0, 32'd1);
    endtask

    initial begin
        int e;
        int bc;
        int d0;

        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        reset_n   = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("rst_busy",  bus.BUSY,  1'b0);
        check("rst_done",  bus.DONE,  1'b0);
        check("rst_z",     bus.Z,     8'h00);
        check("rst_carry", bus.CARRY, 1'b0);

        // Basic shift
        run_op(8'b1011_0011, 8'd3, e, bc);
        check("basic_lat",   e,         5);
        check("basic_busy",  bc,        4);
        check("basic_z",     bus.Z,     8'b1001_1000);
        check("basic_carry", bus.CARRY, 1'b1);

        // Boundary amounts
        run_op(8'hA5, 8'd0, e, bc);
        check("b0_lat",   e,         2);
        check("b0_z",     bus.Z,     8'hA5);
        check("b0_carry", bus.CARRY, 1'b0);

        run_op(8'h81, 8'd8, e, bc);
        check("bw_lat",   e,         10);
        check("bw_z",     bus.Z,     8'h00);
        check("bw_carry", bus.CARRY, 1'b1);

        run_op(8'hFF, 8'd200, e, bc);
        check("bbig_lat",   e,         11);
        check("bbig_z",     bus.Z,     8'h00);
        check("bbig_carry", bus.CARRY, 1'b0);

        run_op(8'h5A, 8'd255, e, bc);
        check("bmax_lat", e, 11);

        // Inputs are ignored while shifting
        @(negedge clk);
        d0 = done_seen;
        bus.A = 8'h01; bus.B = 8'd4; bus.START = 1'b1;
        @(negedge clk);
        bus.A = 8'hFF; bus.B = 8'd1; bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        wait_done("stable_timeout");
        check("stable_z",     bus.Z,     8'h10);
        check("stable_carry", bus.CARRY, 1'b0);
        repeat (8) @(negedge clk);
        check("stable_one_done", done_seen - d0, 1);

        // Back-to-back with START held, second op presented during FIN
        bus.A = 8'h03; bus.B = 8'd1; bus.START = 1'b1;
        wait_done("b2b1_timeout");
        check("b2b1_z", bus.Z, 8'h06);
        bus.A = 8'h40; bus.B = 8'd2;
        @(negedge clk);
        check("b2b_accept", bus.BUSY, 1'b1);
        bus.START = 1'b0;
        wait_done("b2b2_timeout");
        check("b2b2_z",     bus.Z,     8'h00);
        check("b2b2_carry", bus.CARRY, 1'b1);

        // Reset mid-operation abandons the op
        @(negedge clk);
        bus.A = 8'hF0; bus.B = 8'd6; bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        d0 = done_seen;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_z",       bus.Z,          8'h00);
        check("abort_busy",    bus.BUSY,       1'b0);
        run_op(8'h0F, 8'd2, e, bc);
        check("post_lat",   e,         4);
        check("post_z",     bus.Z,     8'h3C);
        check("post_carry", bus.CARRY, 1'b0);

        // Random traffic, checked cycle by cycle against the model
        for (int n = 0; n < 600; n++) begin
            bus.START = ($urandom_range(0, 2) != 0);
            bus.A     = 8'($urandom());
            bus.B     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
            reset_n   = ($urandom_range(0, 59) != 0);
            @(negedge clk);
        end
        reset_n   = 1'b1;
        bus.START = 1'b0;
        repeat (15) @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
